// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive front end. RX_IN is synchronised, a falling edge in IDLE
//   starts a frame, each bit is majority-voted from three mid-bit samples,
//   data is assembled LSB first, optional parity and the stop bit are checked,
//   and the result is reported with one-cycle pulses.
//
// Ports
//   CLK        system / oversampling clock
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, asynchronous to CLK
//   PAR_EN     1 = frame carries a parity bit (latched at start detect)
//   PAR_TYP    0 = even, 1 = odd parity (latched at start detect)
//   PRESCALE   CLK cycles per bit, 8/16/32 (latched at start detect)
//   P_DATA     last correctly received byte
//   DATA_VALID one-cycle pulse, P_DATA updated in the same cycle
//   PAR_ERR    one-cycle pulse, parity mismatch on the frame just ended
//   STP_ERR    one-cycle pulse, stop bit sampled low
module uart_rx_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, next_state;
  logic                  rx_sync_p0, rx_s, rx_s_prev;
  logic [PW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [PW-1:0]         p_lat;
  logic                  par_en_lat, par_typ_lat;
  logic                  par_fail;
  logic [2:0]            smp;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [PW-1:0]         half_p;
  logic                  at_smp, at_dec, last_edge, bit_val;
  logic                  start_det, frame_done;
  logic                  dv_nxt, pe_nxt, se_nxt;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Stage p0/p1: two-flop synchroniser, plus the previous value for edge detect
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_prev  <= 1'b1;
    end else begin
      rx_sync_p0 <= RX_IN;
      rx_s       <= rx_sync_p0;
      rx_s_prev  <= rx_s;
    end
  end

  // Bit timing. The arithmetic wraps in PW bits, so an illegal PRESCALE can
  // garble a frame but edge_cnt always reaches p_lat-1 and the FSM moves on.
  assign half_p    = p_lat >> 1;
  assign at_smp    = (edge_cnt == half_p - PW'(2)) || (edge_cnt == half_p - PW'(1)) ||
                     (edge_cnt == half_p);
  assign at_dec    = (edge_cnt == half_p + PW'(1));
  assign last_edge = (edge_cnt == p_lat - PW'(1));
  assign bit_val   = maj3(smp);
  assign start_det = (state == IDLE) && rx_s_prev && !rx_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    frame_done = 1'b0;
    dv_nxt     = 1'b0;
    pe_nxt     = 1'b0;
    se_nxt     = 1'b0;
    unique case (state)
      IDLE:   if (start_det) next_state = START;
      START: begin
        if (at_dec && bit_val)  next_state = IDLE;   // glitch, not a start bit
        else if (last_edge)     next_state = DATA;
      end
      DATA:   if (last_edge && (bit_cnt == BW'(DATA_WIDTH - 1)))
                next_state = par_en_lat ? PARITY : STOP;
      PARITY: if (last_edge) next_state = STOP;
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (at_dec) begin
          frame_done = 1'b1;
          dv_nxt     = !par_fail && bit_val;
          pe_nxt     = par_fail;
          se_nxt     = !bit_val;
          next_state = IDLE;
        end else if (last_edge) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage p2: frame control, counters, error flags and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      p_lat       <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      par_fail    <= 1'b0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      if (state == IDLE || next_state == IDLE || last_edge) edge_cnt <= '0;
      else                                                  edge_cnt <= edge_cnt + PW'(1);

      if (state != DATA)  bit_cnt <= '0;
      else if (last_edge) bit_cnt <= bit_cnt + BW'(1);

      if (start_det) begin
        p_lat       <= PRESCALE;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
      end

      if (state != IDLE && next_state == IDLE)
        par_fail <= 1'b0;
      else if (state == PARITY && at_dec)
        par_fail <= bit_val != ((^shift_reg) ^ par_typ_lat);

      DATA_VALID <= dv_nxt;
      PAR_ERR    <= pe_nxt;
      STP_ERR    <= se_nxt;
      if (frame_done && dv_nxt) P_DATA <= shift_reg;
    end
  end

  // Sample and data registers carry no reset; they are always rewritten
  // before being used by a frame.
  always_ff @(posedge CLK) begin
    if (at_smp) smp <= {smp[1:0], rx_s};
    if (state == DATA && at_dec) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Drives UART frames onto RX_IN and compares every output pulse against a
//   frame-level reference model (expected byte, error flags and pulse cycle).
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  uart_rx_deserializer dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .PRESCALE(PRESCALE), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pd;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_pdata = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    ev_t e;
    if (RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      e.cyc = cyc; e.dv = DATA_VALID; e.pe = PAR_ERR; e.se = STP_ERR; e.pd = P_DATA;
      obs_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Sends one frame with bitlen cycles per bit and records the expected pulse.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit flip, input bit stp, input int bitlen, input bit timed);
    ev_t e;
    bit  par;
    PRESCALE = p[5:0]; PAR_EN = pe; PAR_TYP = pt;
    // parity bit makes the count of ones even (pt=0) or odd (pt=1)
    par = (($countones(d) % 2) != 0) ^ pt ^ flip;
    e.dv = !flip && stp;
    e.pe = flip;
    e.se = !stp;
    if (e.dv) model_pdata = d;
    e.pd = model_pdata;
    // 2 synchroniser cycles, then 1 + P*(bits before stop) + P/2 + 2
    e.cyc = timed ? cyc + 2 + 1 + p * (9 + int'(pe)) + p / 2 + 2 : -1;
    exp_q.push_back(e);
    drive_bit(1'b0, bitlen);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bitlen);
    if (pe) drive_bit(par, bitlen);
    drive_bit(stp, bitlen);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].cyc >= 0) check({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
      check({tag, "_dv"}, obs_q[i].dv, exp_q[i].dv);
      check({tag, "_perr"}, obs_q[i].pe, exp_q[i].pe);
      check({tag, "_serr"}, obs_q[i].se, exp_q[i].se);
      check({tag, "_pdata"}, obs_q[i].pd, exp_q[i].pd);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_bad;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_pdata", P_DATA, 0);
    check("reset_dv", DATA_VALID, 0);
    check("reset_perr", PAR_ERR, 0);
    check("reset_serr", STP_ERR, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    drive_bit(1'b1, 5);

    // 8N1 at P=8
    send_frame(8'hA5, 8, 0, 0, 0, 1, 8, 1);
    drive_bit(1'b1, 20);
    compare_events("8n1");

    // 8E1 at P=16, good parity then bad parity
    send_frame(8'h3C, 16, 1, 0, 0, 1, 16, 1);
    drive_bit(1'b1, 10);
    send_frame(8'h3C, 16, 1, 0, 1, 1, 16, 1);
    drive_bit(1'b1, 30);
    compare_events("8e1");

    // bad stop bit, line held low (break), then a good frame
    send_frame(8'h81, 8, 0, 0, 0, 0, 8, 1);
    drive_bit(1'b0, 40 * 8);
    drive_bit(1'b1, 16);
    send_frame(8'h42, 8, 0, 0, 0, 1, 8, 1);
    drive_bit(1'b1, 20);
    compare_events("break");

    // 3-cycle glitch must not produce a frame
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 60);
    compare_events("glitch");
    send_frame(8'h11, 16, 0, 0, 0, 1, 16, 1);
    drive_bit(1'b1, 30);
    compare_events("post_glitch");

    // back-to-back 8O1 at P=32: nominal, slow and fast transmitter
    send_frame(8'h55, 32, 1, 1, 0, 1, 32, 1);
    send_frame(8'hFF, 32, 1, 1, 0, 1, 32, 1);
    drive_bit(1'b1, 40);
    compare_events("b2b");
    send_frame(8'h55, 32, 1, 1, 0, 1, 33, 0);
    send_frame(8'hFF, 32, 1, 1, 0, 1, 33, 0);
    drive_bit(1'b1, 40);
    compare_events("b2b_slow");
    send_frame(8'h55, 32, 1, 1, 0, 1, 31, 0);
    send_frame(8'hFF, 32, 1, 1, 0, 1, 31, 0);
    drive_bit(1'b1, 40);
    compare_events("b2b_fast");

    // randomized frames, mixed settings, occasional errors and zero gaps
    prev_bad = 1'b0;
    for (int n = 0; n < 16; n++) begin
      int         p, r;
      bit         pe, pt, flip, stp;
      logic [7:0] d;
      p    = 8 << $urandom_range(0, 2);
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      r    = int'($urandom_range(0, 5));
      flip = pe && (r == 0);
      stp  = (r != 1);
      if (prev_bad || $urandom_range(0, 1) == 1) drive_bit(1'b1, int'($urandom_range(1, 20)));
      send_frame(d, p, pe, pt, flip, stp, p, 1);
      prev_bad = !stp;
    end
    drive_bit(1'b1, 60);
    compare_events("rand");

    // reset in data bit 4 of 0xF0, then a fresh 0x0F frame
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 8);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #2;
    check("rst_mid_pdata", P_DATA, 0);
    check("rst_mid_dv", DATA_VALID, 0);
    check("rst_mid_perr", PAR_ERR, 0);
    check("rst_mid_serr", STP_ERR, 0);
    model_pdata = 8'h00;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    drive_bit(1'b1, 40);
    compare_events("rst_abort");
    send_frame(8'h0F, 8, 0, 0, 0, 1, 8, 1);
    drive_bit(1'b1, 20);
    compare_events("rst_recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
